// File: rtl/poly_mac_acc.sv
// Serial-by-parallel polynomial multiply-accumulate.
// One coefficient of a per accepted beat is scaled by all of b_reg and summed into acc.
module poly_mac_acc #(
  parameter int W = 4,
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*W-1:0]     b,
  input  logic               coef_valid,
  input  logic [W-1:0]       dcoef,
  output logic               busy,
  output logic               done,
  output logic [(2*N-1)*W-1:0] prod
);

  localparam int M  = 2*N-1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*W-1:0] breg_q, breg_d;
  logic [M*W-1:0] acc_q, acc_d;
  logic [M*W-1:0] prod_q, prod_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    breg_d  = breg_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          breg_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (coef_valid) begin
          // a[cnt]*b[j] lands in acc[cnt+j]
          for (int k = 0; k < M; k++) begin
            for (int j = 0; j < N; j++) begin
              if (int'(cnt_q) + j == k) begin
                acc_d[k*W +: W] = acc_d[k*W +: W]
                  + W'(dcoef * breg_q[j*W +: W]);
              end
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) begin
            state_d = DONE;
            prod_d  = acc_d;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      breg_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      breg_q  <= breg_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign busy = (state_q == ACC);
  assign done = (state_q == DONE);
  assign prod = prod_q;

endmodule

// File: tb/tb_poly_mac_acc.sv
// Directed and randomized checks of poly_mac_acc against a
// plain-arithmetic polynomial product model.
module tb_poly_mac_acc;

  localparam int W = 4;
  localparam int N = 4;
  localparam int M = 2*N-1;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N*W-1:0] b;
  logic           coef_valid;
  logic [W-1:0]   dcoef;
  logic           busy;
  logic           done;
  logic [M*W-1:0] prod;

  int checks = 0;
  int errors = 0;

  poly_mac_acc #(.W(W), .N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .b(b),
    .coef_valid(coef_valid), .dcoef(dcoef),
    .busy(busy), .done(done), .prod(prod)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // c[k] = sum over i+j=k of a[i]*b[j], reduced mod 2^W
  function automatic logic [M*W-1:0] ref_prod(
    input logic [N*W-1:0] bv, input logic [N*W-1:0] av);
    int c [M];
    logic [M*W-1:0] r;
    for (int k = 0; k < M; k++) c[k] = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        c[i+j] += int'(av[i*W +: W]) * int'(bv[j*W +: W]);
    r = '0;
    for (int k = 0; k < M; k++)
      r[k*W +: W] = W'(c[k] % (1 << W));
    return r;
  endfunction

  // bub holds 2 bits per beat: number of idle cycles before that beat
  task automatic run(input string tag, input logic [N*W-1:0] bv,
                     input logic [N*W-1:0] av, input logic [2*N-1:0] bub,
                     input bit disturb, input logic [M*W-1:0] expc);
    logic [M*W-1:0] old_prod;
    int nb;
    old_prod = prod;
    b = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, ":start"}, {busy, done}, 2'b10);
    chk({tag, ":hold0"}, prod, old_prod);
    for (int i = 0; i < N; i++) begin
      nb = int'(bub[2*i +: 2]);
      for (int k = 0; k < nb; k++) begin
        coef_valid = 1'b0;
        dcoef = W'($urandom);
        step();
        chk({tag, ":bub"}, {busy, done}, 2'b10);
      end
      if (disturb && i == 1) begin
        start = 1'b1;
        b = {N{W'(7)}};
      end
      coef_valid = 1'b1;
      dcoef = av[i*W +: W];
      step();
      start = 1'b0;
      coef_valid = 1'b0;
      if (i < N-1)
        chk({tag, ":beat"}, {busy, done}, 2'b10);
    end
    chk({tag, ":done"}, {busy, done}, 2'b01);
    chk({tag, ":prod"}, prod, expc);
    coef_valid = 1'b1;
    dcoef = W'($urandom);
    step();
    coef_valid = 1'b0;
    chk({tag, ":idle"}, {busy, done}, 2'b00);
    chk({tag, ":keep"}, prod, expc);
  endtask

  initial begin
    logic [N*W-1:0] rb, ra;
    logic [2*N-1:0] rbub;
    reset = 1'b1;
    start = 1'b0;
    b = '0;
    coef_valid = 1'b0;
    dcoef = '0;
    step();
    step();
    chk("rst_flags", {busy, done}, 2'b00);
    chk("rst_prod", prod, '0);
    reset = 1'b0;

    // coef_valid in IDLE is ignored
    coef_valid = 1'b1;
    dcoef = 4'hF;
    step();
    coef_valid = 1'b0;
    chk("idle_ign", {busy, done, prod}, '0);

    run("basic", 16'h1111, 16'h4321, '0, 1'b0, 28'h479A631);
    chk("basic_model", ref_prod(16'h1111, 16'h4321), 28'h479A631);
    run("wrap", 16'hFFFF, 16'hFFFF, '0, 1'b0, 28'h1234321);
    run("bubble", 16'h1111, 16'h4321, 8'b0000_1000, 1'b0, 28'h479A631);
    run("disturb", 16'h1111, 16'h4321, '0, 1'b1, 28'h479A631);

    // abort after 2 beats
    b = 16'h1111;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      coef_valid = 1'b1;
      dcoef = W'(i + 1);
      step();
    end
    coef_valid = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("abort_flags", {busy, done}, 2'b00);
    chk("abort_prod", prod, '0);
    step();
    chk("abort_nodone", {busy, done}, 2'b00);
    run("after_abort", 16'h1111, 16'h4321, '0, 1'b0, 28'h479A631);

    run("dcsr", 16'h0001, 16'h016A, '0, 1'b0, 28'h000016A);

    for (int r = 0; r < 25; r++) begin
      rb = N*W'($urandom);
      ra = N*W'($urandom);
      rbub = 2*N'($urandom);
      run("rand", rb, ra, rbub, r[0], ref_prod(rb, ra));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
